z_link_sequencer: RTL and testbench

//  Sequences one inference on FPGA1: debounces the start button and pulses start into the linear layer.

---
 rtl/fpga_link_pkg.sv | 11 +
 rtl/btn_debounce.sv | 35 +++
 rtl/z_link_sequencer.sv | 105 ++++++++++
 tb/tb_z_link_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fpga_link_pkg.sv
// fpga_link_pkg: state encoding and default constants shared by the FPGA1->FPGA2 link logic.
package fpga_link_pkg;
   typedef enum logic [2:0] {IDLE, START, WAIT_DONE, LATCH, SEND, DROP, ERR} link_state_t;
   localparam int Z_W              = 4;
   localparam int DEBOUNCE_CYC_DEF = 500000;
   localparam int COMP_TIMEOUT_DEF = 1024;
   localparam int ACK_TIMEOUT_DEF  = 50000000;
   function automatic int max2(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a bouncy button, accepts a new level after CYC stable cycles,
// and emits a one-cycle req on each accepted rising edge.
module btn_debounce #(
   parameter int CYC = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic req
);
   localparam int CW = $clog2(CYC) + 1;
   logic          s1, s2, level, level_d;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         req     <= 1'b0;
         cnt     <= '0;
      end else begin
         s1      <= btn;
         s2      <= s1;
         level_d <= level;
         req     <= level & ~level_d;
         // any return to the accepted level restarts the stability window
         if (s2 == level) cnt <= '0;
         else if (cnt == CW'(CYC - 1)) begin
            level <= s2;
            cnt   <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/z_link_sequencer.sv
// z_link_sequencer: starts one linear-layer inference per debounced press, latches z and
// hands it to FPGA2 over a 4-phase valid/ack link, with compute and link timeouts.
module z_link_sequencer
   import fpga_link_pkg::*;
#(
   parameter int OUT_DATA_W   = Z_W,
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int COMP_TIMEOUT = COMP_TIMEOUT_DEF,
   parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_btn,
   output logic                  lin_start,
   input  logic                  lin_done,
   input  logic [OUT_DATA_W-1:0] lin_z,
   output logic [OUT_DATA_W-1:0] z_out,
   output logic                  z_valid,
   input  logic                  z_ack,
   output logic                  busy,
   output logic                  err_timeout,
   output logic [2:0]            state_dbg
);
   localparam int TW = $clog2(max2(COMP_TIMEOUT, ACK_TIMEOUT)) + 1;
   localparam logic [TW-1:0] COMP_LIM = TW'(COMP_TIMEOUT);
   localparam logic [TW-1:0] ACK_LIM  = TW'(ACK_TIMEOUT);
   link_state_t   state;
   logic [TW-1:0] timer, timer_inc;
   logic          ack_m, ack_s, req;
   btn_debounce #(.CYC(DEBOUNCE_CYC)) u_deb (
      .clk(clk),
      .rst(rst),
      .btn(start_btn),
      .req(req)
   );
   assign timer_inc = &timer ? timer : timer + 1'b1;
   assign busy      = (state != IDLE) && (state != ERR);
   assign state_dbg = state;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         ack_m       <= 1'b0;
         ack_s       <= 1'b0;
         lin_start   <= 1'b0;
         z_valid     <= 1'b0;
         err_timeout <= 1'b0;
         z_out       <= '0;
      end else begin
         ack_m     <= z_ack;
         ack_s     <= ack_m;
         lin_start <= 1'b0;
         case (state)
            IDLE: if (req && !ack_s) begin
               state     <= START;
               lin_start <= 1'b1;
            end
            START: begin
               err_timeout <= 1'b0;
               timer       <= '0;
               state       <= WAIT_DONE;
            end
            // timer==0 marks the first cycle after START, where a stale done is ignored
            WAIT_DONE: begin
               timer <= timer_inc;
               if (timer_inc == COMP_LIM) begin
                  state       <= ERR;
                  err_timeout <= 1'b1;
               end else if (lin_done && timer != '0) state <= LATCH;
            end
            LATCH: begin
               z_out   <= lin_z;
               timer   <= '0;
               z_valid <= 1'b1;
               state   <= SEND;
            end
            SEND: begin
               timer <= timer_inc;
               if (ack_s) begin
                  state   <= DROP;
                  z_valid <= 1'b0;
                  timer   <= '0;
               end else if (timer_inc == ACK_LIM) begin
                  state       <= ERR;
                  z_valid     <= 1'b0;
                  err_timeout <= 1'b1;
               end
            end
            DROP: begin
               timer <= timer_inc;
               if (!ack_s) state <= IDLE;
               else if (timer_inc == ACK_LIM) begin
                  state       <= ERR;
                  err_timeout <= 1'b1;
               end
            end
            ERR: if (req) begin
               state     <= START;
               lin_start <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_z_link_sequencer.sv
// tb_z_link_sequencer: directed scenarios with a spec-level monitor and z scoreboard.
module tb_z_link_sequencer;
   localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_WAIT = 3'd2, S_LATCH = 3'd3,
                          S_SEND = 3'd4, S_DROP = 3'd5, S_ERR = 3'd6;
   logic       clk = 1'b0, rst = 1'b1, start_btn = 1'b0, lin_done = 1'b0, z_ack = 1'b0;
   logic [3:0] lin_z = 4'h0;
   logic       lin_start, z_valid, busy, err_timeout;
   logic [3:0] z_out;
   logic [2:0] state_dbg;
   int         checks = 0, fails = 0, n_start = 0, run = 0, n, s0;
   logic [3:0] exp_z[$];
   logic [3:0] e, p_z;
   logic [2:0] p_st;
   logic       p_zv;

   z_link_sequencer #(.OUT_DATA_W(4), .DEBOUNCE_CYC(8), .COMP_TIMEOUT(16), .ACK_TIMEOUT(32)) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn), .lin_start(lin_start), .lin_done(lin_done),
      .lin_z(lin_z), .z_out(z_out), .z_valid(z_valid), .z_ack(z_ack), .busy(busy),
      .err_timeout(err_timeout), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_start(input int lim, output int k);
      k = 0;
      while (!lin_start && k < lim) begin @(negedge clk); k++; end
      check("lin_start_seen", int'(lin_start), 1);
   endtask

   task automatic wait_zv(input logic v, input int lim, output int k);
      k = 0;
      while (z_valid !== v && k < lim) begin @(negedge clk); k++; end
      check("z_valid_reached", int'(z_valid === v), 1);
   endtask

   task automatic wait_state(input logic [2:0] s, input int lim, output int k);
      k = 0;
      while (state_dbg !== s && k < lim) begin @(negedge clk); k++; end
      check("state_reached", int'(state_dbg), int'(s));
   endtask

   task automatic release_btn();
      start_btn = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   task automatic run_txn(input logic [3:0] z, input int done_dly, input int ack_dly);
      int k;
      repeat (done_dly) @(negedge clk);
      lin_z = z; lin_done = 1'b1; exp_z.push_back(z);
      wait_zv(1'b1, 8, k); check("done_to_valid", k, 2);
      lin_done = 1'b0;
      repeat (ack_dly) @(negedge clk);
      z_ack = 1'b1;
      wait_zv(1'b0, 8, k); check("ack_to_valid_low", k, 3);
      z_ack = 1'b0;
      wait_state(S_IDLE, 8, k); check("ack_low_to_idle", k, 3);
   endtask

   // spec-rule monitor: output/state consistency, z scoreboard, timeout run lengths
   always @(negedge clk) begin
      if (rst) begin
         p_st = S_IDLE; p_zv = 1'b0; p_z = 4'h0; run = 0;
      end else begin
         check("valid_only_in_send", int'(z_valid), int'(state_dbg == S_SEND));
         check("start_only_in_start", int'(lin_start), int'(state_dbg == S_START));
         check("busy_rule", int'(busy), int'(state_dbg != S_IDLE && state_dbg != S_ERR));
         if (lin_start) n_start++;
         if (z_out != p_z) check("z_changes_after_latch", int'(p_st), int'(S_LATCH));
         if (z_valid && !p_zv) begin
            if (exp_z.size() == 0) check("valid_expected", exp_z.size(), 1);
            else begin
               e = exp_z.pop_front();
               check("z_out_on_valid", int'(z_out), int'(e));
            end
         end
         if (z_valid && p_zv) check("z_stable_while_valid", int'(z_out), int'(p_z));
         if (state_dbg == p_st) run++;
         else begin
            if (state_dbg == S_ERR && p_st == S_WAIT) check("comp_timeout_len", run, 16);
            if (state_dbg == S_ERR && p_st == S_SEND) check("ack_timeout_len", run, 32);
            run = 1;
         end
         p_st = state_dbg; p_zv = z_valid; p_z = z_out;
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_z_out", int'(z_out), 0);
      check("rst_z_valid", int'(z_valid), 0);
      check("rst_lin_start", int'(lin_start), 0);
      check("rst_err", int'(err_timeout), 0);
      check("rst_state", int'(state_dbg), int'(S_IDLE));
      rst = 1'b0;
      repeat (2) @(negedge clk);
      // 1: clean press and normal handshake
      s0 = n_start; start_btn = 1'b1;
      wait_start(40, n); check("press_to_lin_start", n, 12);
      run_txn(4'hA, 4, 5);
      check("t1_one_start", n_start - s0, 1);
      check("t1_z_out", int'(z_out), 10);
      release_btn();
      // 2: bouncing button
      s0 = n_start;
      for (int i = 0; i < 10; i++) begin
         start_btn = ~i[0];
         repeat (3) @(negedge clk);
      end
      check("t2_no_start_while_bouncing", n_start - s0, 0);
      start_btn = 1'b1;
      wait_start(40, n);
      run_txn(4'h5, 3, 2);
      repeat (20) @(negedge clk);
      check("t2_one_start", n_start - s0, 1);
      release_btn();
      // 3: compute timeout, then recovery
      start_btn = 1'b1;
      wait_start(40, n);
      wait_state(S_ERR, 30, n); check("t3_start_to_err", n, 17);
      check("t3_err_flag", int'(err_timeout), 1);
      check("t3_z_valid", int'(z_valid), 0);
      check("t3_busy", int'(busy), 0);
      release_btn();
      start_btn = 1'b1;
      wait_start(40, n);
      check("t3_err_held_in_start", int'(err_timeout), 1);
      @(negedge clk);
      check("t3_err_cleared", int'(err_timeout), 0);
      run_txn(4'h3, 2, 1);
      release_btn();
      // 4: second press during SEND is dropped
      s0 = n_start; start_btn = 1'b1;
      wait_start(40, n);
      start_btn = 1'b0;
      repeat (2) @(negedge clk);
      lin_z = 4'hC; lin_done = 1'b1; exp_z.push_back(4'hC);
      wait_zv(1'b1, 8, n); check("t4_done_to_valid", n, 2);
      lin_done = 1'b0;
      repeat (10) @(negedge clk);
      start_btn = 1'b1;
      repeat (14) @(negedge clk);
      check("t4_still_send", int'(state_dbg), int'(S_SEND));
      z_ack = 1'b1;
      wait_zv(1'b0, 8, n);
      z_ack = 1'b0;
      wait_state(S_IDLE, 8, n);
      repeat (20) @(negedge clk);
      check("t4_one_start", n_start - s0, 1);
      check("t4_idle", int'(state_dbg), int'(S_IDLE));
      check("t4_z_out", int'(z_out), 12);
      release_btn();
      // 5: stale done held high, then ack timeout
      lin_z = 4'h7; lin_done = 1'b1; exp_z.push_back(4'h7);
      start_btn = 1'b1;
      wait_start(40, n);
      @(negedge clk); check("t5_skip_stale_done", int'(state_dbg), int'(S_WAIT));
      @(negedge clk); check("t5_wait_second", int'(state_dbg), int'(S_WAIT));
      @(negedge clk); check("t5_latch", int'(state_dbg), int'(S_LATCH));
      wait_state(S_ERR, 40, n); check("t5_latch_to_err", n, 33);
      check("t5_err_flag", int'(err_timeout), 1);
      check("t5_z_out_held", int'(z_out), 7);
      check("t5_z_valid", int'(z_valid), 0);
      lin_done = 1'b0;
      release_btn();
      // 6: asynchronous reset in WAIT_DONE and in SEND
      start_btn = 1'b1;
      wait_start(40, n);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6a_z_valid", int'(z_valid), 0);
      check("t6a_lin_start", int'(lin_start), 0);
      check("t6a_state", int'(state_dbg), int'(S_IDLE));
      check("t6a_z_out", int'(z_out), 0);
      @(negedge clk);
      start_btn = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      start_btn = 1'b1;
      wait_start(40, n);
      repeat (2) @(negedge clk);
      lin_z = 4'h9; lin_done = 1'b1; exp_z.push_back(4'h9);
      wait_zv(1'b1, 8, n);
      lin_done = 1'b0;
      repeat (5) @(negedge clk);
      check("t6b_in_send", int'(state_dbg), int'(S_SEND));
      #2 rst = 1'b1;
      #1;
      check("t6b_z_valid", int'(z_valid), 0);
      check("t6b_lin_start", int'(lin_start), 0);
      check("t6b_state", int'(state_dbg), int'(S_IDLE));
      check("t6b_z_out", int'(z_out), 0);
      @(negedge clk);
      start_btn = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("t6_final_idle", int'(state_dbg), int'(S_IDLE));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
